memory_access_stage: RTL and testbench
======================================

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum ACCESS cycles to wait for dmemReady before aborting.
REQ-002 SHALL have a single clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-003 clk  in  1  pipeline clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 valid  in  1  EX/MEM holds a live instruction.
REQ-006 memRead / memWrite / memToReg / regWrite  in  1 each  control bits from EX/MEM.
REQ-007 funct3  in  3  access size: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-008 address  in  32  ALU result, used as the effective address.
REQ-009 writeData  in  32  store data (rs2).
REQ-010 dmemReq / dmemWe  out  1 each  memory request and write strobe.
REQ-011 dmemAddr  out  32  word-aligned address ({address[31:2],2'b00}).
REQ-012 dmemWdata  out  32 / dmemByteEnable  out  4  lane-placed store data and lane enables.
REQ-013 dmemReady  in  1 / dmemRdata  in  32  memory completion and read word.
REQ-014 memMemoryData / memExecutionData  out  32 each  load result and pass-through ALU result, both to MEM/WB.
REQ-015 memShouldUseMemoryData / memIsRegisterWrite  out  1 each  write-back select and enable, both to MEM/WB.
REQ-016 stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-017 misaligned / busError  out  1 each  single-cycle fault flags.

Function
REQ-018 FSM states are IDLE, ACCESS and DONE.
REQ-019 IDLE with valid=0, or with memRead=memWrite=0: stall=0, zero latency; outputs are address, memToReg and regWrite&valid.
REQ-020 IDLE with valid and an aligned memory op: stall=1 combinationally and memIsRegisterWrite=0; next state ACCESS; address, data, size and direction are registered.
REQ-021 ACCESS: dmemReq=1 and stall=1; dmemWe=1 for stores; the request fields stay stable until dmemReady=1.
REQ-022 ACCESS with dmemReady=1: dmemRdata is captured and the next state is DONE.
REQ-023 DONE: stall=0 and dmemReq=0; outputs present the completed result for one cycle; next state IDLE unconditionally, so the same held op never re-issues.
REQ-024 Load result: the byte or half is selected by address[1:0] or address[1] and is sign- or zero-extended per funct3; an unlisted funct3 value is treated as word.
REQ-025 Store enables and data:
- byte: enable 1<<address[1:0], data byte replicated on all four lanes.
- half: enable 0011 or 1100, data half replicated on both halves.
- word: enable 1111.
REQ-026 For stores memShouldUseMemoryData=0; for loads it equals the registered memToReg.
REQ-027 memRead=memWrite=1 is treated as a store.
REQ-028 A half access with address[0]=1, or a word access with address[1:0]≠0:
- no request is issued.
- misaligned=1 for that cycle; stall=0; memIsRegisterWrite=0.
REQ-029 Timeout: a counter clears on entry to ACCESS; after MEM_TIMEOUT cycles without dmemReady the FSM goes to DONE with busError=1, memIsRegisterWrite=0 and memMemoryData=0.
REQ-030 memExecutionData always carries the (registered, while busy) address unchanged.
REQ-031 Minimum load/store latency is 3 cycles: IDLE→ACCESS→DONE with dmemReady=1 in the first ACCESS cycle.

Reset
REQ-032 Reset SHALL force state IDLE and clear the timeout counter and capture registers.
REQ-033 On the reset edge, dmemReq, dmemWe, stall, misaligned, busError, memIsRegisterWrite and memShouldUseMemoryData SHALL be 0, and all 32-bit outputs SHALL be 0.
REQ-034 Reset during ACCESS drops dmemReq on that edge; a later dmemReady is ignored.

Verification
REQ-035 LW at 0x100, dmemRdata=0xDEADBEEF, ready on the first ACCESS cycle → stall high 2 cycles; in DONE, memMemoryData=0xDEADBEEF and memIsRegisterWrite=1.
REQ-036 LB at 0x103 with rdata 0x80FFFFFF → 0xFFFFFF80; LBU → 0x00000080; LHU at 0x102 with rdata 0x8001FFFF → 0x00008001.
REQ-037 SB at 0x21, writeData 0x000000AB → dmemByteEnable=0010, dmemWdata=0xABABABAB, dmemAddr=0x20, dmemWe=1.
REQ-038 LW at 0x102 → misaligned=1, no dmemReq, stall=0, memIsRegisterWrite=0.
REQ-039 dmemReady held 0 with MEM_TIMEOUT=4 → busError=1 in DONE after 4 ACCESS cycles; reset asserted mid-ACCESS instead → all outputs 0 next cycle.

Source files
------------

// File: rtl/memory_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_stage_if
// Brief    : Data-memory request/response bus between the MEM stage and memory.
// Revision : 1.0
// ============================================================================
interface memory_access_stage_if;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemByteEnable;
    logic        dmemReady;
    logic [31:0] dmemRdata;

    modport master (
        output dmemReq,
        output dmemWe,
        output dmemAddr,
        output dmemWdata,
        output dmemByteEnable,
        input  dmemReady,
        input  dmemRdata
    );

    modport slave (
        input  dmemReq,
        input  dmemWe,
        input  dmemAddr,
        input  dmemWdata,
        input  dmemByteEnable,
        output dmemReady,
        output dmemRdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_stage
// Brief    : Pipeline MEM stage: issues loads/stores with a timeout, stalls the
//            front of the pipe while busy and formats load results.
// Revision : 1.0
// ============================================================================
module memory_access_stage #(
    parameter int MEM_TIMEOUT = 16
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   valid,
    input  wire                   memRead,
    input  wire                   memWrite,
    input  wire                   memToReg,
    input  wire                   regWrite,
    input  wire  [2:0]            funct3,
    input  wire  [31:0]           address,
    input  wire  [31:0]           writeData,
    memory_access_stage_if.master dmem,
    output logic [31:0]           memMemoryData,
    output logic [31:0]           memExecutionData,
    output logic                  memShouldUseMemoryData,
    output logic                  memIsRegisterWrite,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  busError
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             store_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             memToReg_q;
    logic             regWrite_q;
    logic             busErr_q;
    logic [31:0]      result_q;

    logic [1:0]       size_d;
    logic             isMem_d;
    logic             misalign_d;
    logic             start_d;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;

    // Unlisted funct3 encodings fall through to word accesses.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        logic [1:0] s;
        case (f3)
            3'b000, 3'b100: s = SZ_BYTE;
            3'b001, 3'b101: s = SZ_HALF;
            default:        s = SZ_WORD;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [31:0] rdata,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign size_d     = size_of(funct3);
    assign isMem_d    = valid & (memRead | memWrite);
    assign misalign_d = ((size_d == SZ_HALF) & address[0]) |
                        ((size_d == SZ_WORD) & (address[1:0] != 2'b00));
    assign start_d    = isMem_d & ~misalign_d;

    // Stores place the datum on every lane it could occupy; enables pick the lane.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = writeData;
        case (size_d)
            SZ_BYTE: begin
                be_d    = 4'b0001 << address[1:0];
                wdata_d = {4{writeData[7:0]}};
            end
            SZ_HALF: begin
                be_d    = address[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{writeData[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = writeData;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            store_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            memToReg_q <= 1'b0;
            regWrite_q <= 1'b0;
            busErr_q   <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q    <= S_ACCESS;
                        cnt_q      <= '0;
                        addr_q     <= address;
                        wdata_q    <= wdata_d;
                        be_q       <= be_d;
                        store_q    <= memWrite;
                        size_q     <= size_d;
                        uns_q      <= funct3[2];
                        memToReg_q <= memToReg;
                        regWrite_q <= regWrite;
                        busErr_q   <= 1'b0;
                        result_q   <= '0;
                    end
                end
                S_ACCESS: begin
                    if (dmem.dmemReady) begin
                        result_q <= store_q ? 32'd0
                                            : load_extend(dmem.dmemRdata, addr_q[1:0], size_q, uns_q);
                        state_q  <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        busErr_q <= 1'b1;
                        result_q <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Always return to IDLE so the still-held EX/MEM op cannot re-issue.
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dmem.dmemReq           = 1'b0;
        dmem.dmemWe            = 1'b0;
        dmem.dmemAddr          = '0;
        dmem.dmemWdata         = '0;
        dmem.dmemByteEnable    = '0;
        memMemoryData          = '0;
        memExecutionData       = '0;
        memShouldUseMemoryData = 1'b0;
        memIsRegisterWrite     = 1'b0;
        stall                  = 1'b0;
        misaligned             = 1'b0;
        busError               = 1'b0;
        // Reset blanks every output immediately, including a request in flight.
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    memExecutionData = address;
                    if (!isMem_d) begin
                        memShouldUseMemoryData = memToReg;
                        memIsRegisterWrite     = regWrite & valid;
                    end else if (misalign_d) begin
                        misaligned = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                S_ACCESS: begin
                    dmem.dmemReq        = 1'b1;
                    dmem.dmemWe         = store_q;
                    dmem.dmemAddr       = {addr_q[31:2], 2'b00};
                    dmem.dmemWdata      = wdata_q;
                    dmem.dmemByteEnable = be_q;
                    stall               = 1'b1;
                    memExecutionData    = addr_q;
                end
                S_DONE: begin
                    memExecutionData       = addr_q;
                    memMemoryData          = result_q;
                    busError               = busErr_q;
                    memIsRegisterWrite     = regWrite_q & ~busErr_q;
                    memShouldUseMemoryData = ~store_q & memToReg_q;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_stage
// Brief    : Random and directed stimulus against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_memory_access_stage;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0, memRead = 1'b0, memWrite = 1'b0, memToReg = 1'b0, regWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = 32'd0, writeData = 32'd0;
    logic [31:0] memMemoryData, memExecutionData;
    logic        memShouldUseMemoryData, memIsRegisterWrite, stall, misaligned, busError;

    memory_access_stage_if bus();

    memory_access_stage #(.MEM_TIMEOUT(T)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .valid                  (valid),
        .memRead                (memRead),
        .memWrite               (memWrite),
        .memToReg               (memToReg),
        .regWrite               (regWrite),
        .funct3                 (funct3),
        .address                (address),
        .writeData              (writeData),
        .dmem                   (bus),
        .memMemoryData          (memMemoryData),
        .memExecutionData       (memExecutionData),
        .memShouldUseMemoryData (memShouldUseMemoryData),
        .memIsRegisterWrite     (memIsRegisterWrite),
        .stall                  (stall),
        .misaligned             (misaligned),
        .busError               (busError)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req, we, stall, mis, berr, rw, usemem, chk_usemem, chk_mdata, done;
        logic [31:0] addr, wdata, mdata, edata;
        logic [3:0]  be;
    } exp_t;

    exp_t        cur;
    bit          exp_on = 0;
    int          tests = 0, fails = 0;
    int          stall_cnt, req_cnt;
    bit          seen_mis, seen_rw_any, seen_berr, seen_we;
    logic [31:0] seen_mdata, seen_addr, seen_wdata;
    logic [3:0]  seen_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference rules, computed arithmetically from the access definition.
    function automatic int sz(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 0;
        if (f3 == 3'b001 || f3 == 3'b101) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] ld(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        if (sz(f3) == 0) begin
            v = (rd >> (8 * a[1:0])) & 32'hFF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz(f3) == 1) begin
            v = (rd >> (16 * a[1])) & 32'hFFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] st_be(input logic [31:0] a, input logic [2:0] f3);
        if (sz(f3) == 0) return 4'b0001 << a[1:0];
        if (sz(f3) == 1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] st_data(input logic [31:0] wd, input logic [2:0] f3);
        if (sz(f3) == 0) return {24'd0, wd[7:0]} * 32'h01010101;
        if (sz(f3) == 1) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_on) begin
                chk("dmemReq", bus.dmemReq, cur.req);
                chk("dmemWe", bus.dmemWe, cur.we);
                chk("stall", stall, cur.stall);
                chk("misaligned", misaligned, cur.mis);
                chk("busError", busError, cur.berr);
                chk("memIsRegisterWrite", memIsRegisterWrite, cur.rw);
                chk("memExecutionData", memExecutionData, cur.edata);
                if (cur.req) begin
                    chk("dmemAddr", bus.dmemAddr, cur.addr);
                    chk("dmemWdata", bus.dmemWdata, cur.wdata);
                    chk("dmemByteEnable", bus.dmemByteEnable, cur.be);
                end
                if (cur.chk_mdata)  chk("memMemoryData", memMemoryData, cur.mdata);
                if (cur.chk_usemem) chk("memShouldUseMemoryData", memShouldUseMemoryData, cur.usemem);
                if (stall) stall_cnt++;
                if (misaligned) seen_mis = 1;
                if (memIsRegisterWrite) seen_rw_any = 1;
                if (bus.dmemReq) begin
                    req_cnt++;
                    seen_addr  = bus.dmemAddr;
                    seen_wdata = bus.dmemWdata;
                    seen_be    = bus.dmemByteEnable;
                    seen_we    = bus.dmemWe;
                end
                if (cur.done) begin
                    seen_mdata = memMemoryData;
                    seen_berr  = busError;
                end
            end
        end
    end

    // One EX/MEM instruction from presentation to the cycle the stage releases it.
    task automatic run_op(input bit v, input bit rd, input bit wr, input bit m2r, input bit rw,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int delay, input logic [31:0] rdata);
        exp_t e;
        bit   mem, mis, tmo;
        int   s;
        s   = sz(f3);
        mem = v && (rd || wr);
        mis = (s == 1 && a[0]) || (s == 2 && a[1:0] != 2'b00);
        @(negedge clk);
        stall_cnt = 0; req_cnt = 0; seen_mis = 0; seen_rw_any = 0; seen_berr = 0;
        reset = 0; valid = v; memRead = rd; memWrite = wr; memToReg = m2r; regWrite = rw;
        funct3 = f3; address = a; writeData = wd;
        bus.dmemReady = 1'b0; bus.dmemRdata = $urandom;
        e = '0; e.edata = a;
        if (!mem) begin
            e.rw = rw && v; e.usemem = m2r; e.chk_usemem = 1;
            cur = e; exp_on = 1;
            return;
        end
        if (mis) begin
            e.mis = 1; cur = e; exp_on = 1;
            return;
        end
        e.stall = 1; cur = e; exp_on = 1;
        tmo = 1;
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            bus.dmemReady = (i == delay);
            bus.dmemRdata = (i == delay) ? rdata : $urandom;
            e = '0; e.req = 1; e.we = wr; e.stall = 1; e.edata = a;
            e.addr = {a[31:2], 2'b00}; e.be = st_be(a, f3); e.wdata = st_data(wd, f3);
            cur = e;
            if (i == delay) begin
                tmo = 0;
                break;
            end
        end
        @(negedge clk);
        bus.dmemReady = 1'($urandom % 2); bus.dmemRdata = $urandom;
        e = '0; e.done = 1; e.berr = tmo; e.rw = rw && !tmo; e.edata = a;
        if (tmo) begin
            e.mdata = 32'd0; e.chk_mdata = 1;
        end else if (!wr) begin
            e.mdata = ld(rdata, a, f3); e.chk_mdata = 1; e.usemem = m2r; e.chk_usemem = 1;
        end else begin
            e.usemem = 0; e.chk_usemem = 1;
        end
        cur = e;
    endtask

    task automatic reset_mid_access();
        exp_t e;
        @(negedge clk);
        reset = 0; valid = 1; memRead = 1; memWrite = 0; memToReg = 1; regWrite = 1;
        funct3 = 3'b010; address = 32'h80; writeData = 32'd0; bus.dmemReady = 0;
        req_cnt = 0;
        e = '0; e.stall = 1; e.edata = 32'h80; cur = e;
        @(negedge clk);
        e = '0; e.req = 1; e.stall = 1; e.edata = 32'h80; e.addr = 32'h80; e.be = 4'hF; cur = e;
        @(negedge clk);
        reset = 1;
        e = '0; e.chk_mdata = 1; e.chk_usemem = 1; cur = e;
        @(negedge clk);
        bus.dmemReady = 1; bus.dmemRdata = 32'h12345678;
        @(negedge clk);
        reset = 0; valid = 0; memRead = 0; memToReg = 0; regWrite = 0; address = 32'd0;
        @(negedge clk);
        bus.dmemReady = 0;
        #3;
    endtask

    initial begin
        bus.dmemReady = 1'b0;
        bus.dmemRdata = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            valid = 1; memRead = 1; address = $urandom; funct3 = 3'b010;
            cur = '0; cur.chk_mdata = 1; cur.chk_usemem = 1; exp_on = 1;
        end

        run_op(1, 1, 0, 1, 1, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF); #3;
        chk("lw_stall_cycles", stall_cnt, 2);
        chk("lw_data", seen_mdata, 32'hDEADBEEF);
        chk("lw_regwrite", seen_rw_any, 1);
        run_op(1, 1, 0, 1, 1, 3'b000, 32'h103, 32'd0, 0, 32'h80FFFFFF); #3;
        chk("lb_data", seen_mdata, 32'hFFFFFF80);
        run_op(1, 1, 0, 1, 1, 3'b100, 32'h103, 32'd0, 1, 32'h80FFFFFF); #3;
        chk("lbu_data", seen_mdata, 32'h00000080);
        run_op(1, 1, 0, 1, 1, 3'b101, 32'h102, 32'd0, 2, 32'h8001FFFF); #3;
        chk("lhu_data", seen_mdata, 32'h00008001);
        run_op(1, 0, 1, 0, 0, 3'b000, 32'h21, 32'hAB, 0, 32'd0); #3;
        chk("sb_be", seen_be, 4'b0010);
        chk("sb_wdata", seen_wdata, 32'hABABABAB);
        chk("sb_addr", seen_addr, 32'h20);
        chk("sb_we", seen_we, 1);
        run_op(1, 1, 0, 1, 1, 3'b010, 32'h102, 32'd0, 0, 32'd0); #3;
        chk("lw_mis_flag", seen_mis, 1);
        chk("lw_mis_req", req_cnt, 0);
        chk("lw_mis_stall", stall_cnt, 0);
        chk("lw_mis_rw", seen_rw_any, 0);
        run_op(1, 1, 0, 1, 1, 3'b010, 32'h40, 32'd0, 99, 32'd0); #3;
        chk("tmo_berr", seen_berr, 1);
        chk("tmo_req_cycles", req_cnt, T);
        chk("tmo_rw", seen_rw_any, 0);
        reset_mid_access();
        chk("rst_req_cycles", req_cnt, 1);

        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom % 4;
            run_op(($urandom % 8) != 0, k[0], k[1], 1'($urandom % 2), 1'($urandom % 2),
                   3'($urandom % 8), $urandom, $urandom, $urandom % (T + 2), $urandom);
        end
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
